// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle control unit
package mc_pkg;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} cls_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LB = 6'h20, OP_LW = 6'h23, OP_LBU = 6'h24, OP_SB = 6'h28,
                         OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SLLV = 6'h04, F_SRLV = 6'h06,
                         F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_SLL = 4'd4, ALU_SRL = 4'd5, ALU_LUI = 4'd6;
  localparam logic [1:0] MR_ALU = 2'b00, MR_LUI = 2'b01, MR_PC4 = 2'b10, MR_MEM = 2'b11;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instr-to-static-control decoder with legality and class
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output logic        RegDst,
  output logic        ra,
  output logic        ALUsrc_A,
  output logic        ALUsrc_B,
  output logic        Var,
  output logic        ExtOp,
  output logic [3:0]  ALUctr,
  output logic [1:0]  Set,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  lbyte,
  output logic        sbyte,
  output logic        beq,
  output logic        bne,
  output logic        jimm,
  output logic        jreg,
  output logic        link,
  output logic        legal,
  output cls_t        cls
);
  logic [5:0] op, fn;
  logic r, load, store, br, unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];
  assign r = op == OP_R;
  assign load = op inside {OP_LB, OP_LW, OP_LBU};
  assign store = op inside {OP_SB, OP_SW};
  assign beq = op == OP_BEQ;
  assign bne = op == OP_BNE;
  assign br = beq | bne;
  assign jimm = op inside {OP_J, OP_JAL};
  assign jreg = r & (fn inside {F_JR, F_JALR});
  assign link = (op == OP_JAL) | (r & (fn == F_JALR));
  assign legal = r ? fn inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU,
                                F_SLL, F_SRL, F_SLLV, F_SRLV, F_JR, F_JALR}
                   : op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI,
                                OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW};
  assign cls = load ? C_LOAD : store ? C_STORE : br ? C_BRANCH : (jimm | jreg) ? C_JUMP : C_ALU;
  assign RegDst = r;
  assign ra = op == OP_JAL;
  assign ALUsrc_A = r & (fn inside {F_SLL, F_SRL, F_SLLV, F_SRLV});
  assign Var = r & (fn inside {F_SLLV, F_SRLV});
  assign ALUsrc_B = (op inside {OP_ADDIU, OP_ORI, OP_LUI}) | load | store;
  assign ExtOp = (op == OP_ADDIU) | load | store | br;
  assign ALUctr = (br | (r & (fn inside {F_SUB, F_SUBU, F_SLT, F_SLTU}))) ? ALU_SUB :
                  (r & (fn == F_AND))                     ? ALU_AND :
                  ((r & (fn == F_OR)) | (op == OP_ORI))   ? ALU_OR  :
                  (r & (fn inside {F_SLL, F_SLLV}))       ? ALU_SLL :
                  (r & (fn inside {F_SRL, F_SRLV}))       ? ALU_SRL :
                  (op == OP_LUI)                          ? ALU_LUI : ALU_ADD;
  assign Set = {r & (fn == F_SLTU), r & (fn inside {F_SLT, F_SLTU})};
  assign MemtoReg = load ? MR_MEM : link ? MR_PC4 : (op == OP_LUI) ? MR_LUI : MR_ALU;
  assign lbyte = {op == OP_LB, op inside {OP_LB, OP_LBU}};
  assign sbyte = op == OP_SB;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control FSM with gated write strobes, instret and sticky halt
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  output logic [3:0]       Branch,
  output logic             Jump,
  output logic             Jreg,
  output logic             RegDst,
  output logic             ra,
  output logic             ALUsrc_A,
  output logic             ALUsrc_B,
  output logic             Var,
  output logic             ExtOp,
  output logic [3:0]       ALUctr,
  output logic [1:0]       Set,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       lbyte,
  output logic             sbyte,
  output logic             RegWr,
  output logic             MemWr,
  output logic             PCWr,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);
  state_t state;
  cls_t cls;
  logic beq, bne, jimm, jreg, link, legal, ex, fin;
  mc_decode u_dec (
    .instr(instr), .RegDst(RegDst), .ra(ra), .ALUsrc_A(ALUsrc_A), .ALUsrc_B(ALUsrc_B),
    .Var(Var), .ExtOp(ExtOp), .ALUctr(ALUctr), .Set(Set), .MemtoReg(MemtoReg),
    .lbyte(lbyte), .sbyte(sbyte), .beq(beq), .bne(bne), .jimm(jimm), .jreg(jreg),
    .link(link), .legal(legal), .cls(cls)
  );
  assign ex = state == S_EX;
  assign fin = (ex & (cls inside {C_BRANCH, C_JUMP})) | (state == S_MEM & cls == C_STORE)
             | (state == S_WB);
  // strobes are gated by rst so a write pending at a reset edge never lands
  assign PCWr = rst & fin;
  assign RegWr = rst & ((state == S_WB) | (ex & link));
  assign MemWr = rst & (state == S_MEM) & (cls == C_STORE);
  assign Branch = ex ? {2'b00, bne, beq} : 4'b0000;
  assign Jump = ex & jimm;
  assign Jreg = ex & jreg;
  assign halt = state == S_HALT;
  // step sequencing per instruction class and retirement counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IF;
      instret <= '0;
    end else begin
      if (fin) instret <= instret + CNT_W'(1);
      case (state)
        S_IF:    state <= S_ID;
        S_ID:    state <= legal ? S_EX : S_HALT;
        S_EX:    state <= (cls inside {C_BRANCH, C_JUMP}) ? S_IF : (cls inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
        S_MEM:   state <= cls == C_STORE ? S_IF : S_WB;
        S_WB:    state <= S_IF;
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl decode, strobe timing, halt and reset
module tb_mc_ctrl;
  import mc_pkg::*;
  logic clk = 0, rst = 0;
  logic [31:0] instr = 0;
  logic [3:0] Branch, ALUctr;
  logic Jump, Jreg, RegDst, ra, ALUsrc_A, ALUsrc_B, Var, ExtOp, sbyte, RegWr, MemWr, PCWr, halt;
  logic [1:0] Set, MemtoReg, lbyte;
  logic [31:0] instret;
  int checks = 0, errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic [4:0]  pc_m, reg_m, mem_m;
    logic [5:0]  ex;
    logic [16:0] st;
  } vec_t;
  vec_t vecs[19];

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Branch(Branch), .Jump(Jump), .Jreg(Jreg),
    .RegDst(RegDst), .ra(ra), .ALUsrc_A(ALUsrc_A), .ALUsrc_B(ALUsrc_B), .Var(Var),
    .ExtOp(ExtOp), .ALUctr(ALUctr), .Set(Set), .MemtoReg(MemtoReg), .lbyte(lbyte),
    .sbyte(sbyte), .RegWr(RegWr), .MemWr(MemWr), .PCWr(PCWr), .halt(halt), .instret(instret)
  );

  function automatic logic [16:0] st(input logic rd, r31, a, b, v, e, input logic [3:0] alu,
                                     input logic [1:0] set, m2r, lb, input logic sb);
    return {rd, r31, a, b, v, e, alu, set, m2r, lb, sb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " strobes"}, {29'd0, PCWr, RegWr, MemWr}, 32'd0);
  endtask

  // entered at negedge of an S_IF cycle; leaves at negedge of the next S_IF cycle
  task automatic run_vec(input int idx, input vec_t v);
    logic [8:0] exp;
    instr = v.instr;
    #1;
    chk($sformatf("static[%0d]", idx),
        {15'd0, RegDst, ra, ALUsrc_A, ALUsrc_B, Var, ExtOp, ALUctr, Set, MemtoReg, lbyte, sbyte},
        {15'd0, v.st});
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #1;
      end
      exp = {v.pc_m[c-1], v.reg_m[c-1], v.mem_m[c-1], (c == 3) ? v.ex : 6'b0};
      chk($sformatf("cyc[%0d].%0d", idx, c),
          {23'd0, PCWr, RegWr, MemWr, Branch, Jump, Jreg}, {23'd0, exp});
    end
    @(negedge clk);
    exp_cnt++;
    chk($sformatf("instret[%0d]", idx), instret, exp_cnt);
    chk($sformatf("halt[%0d]", idx), {31'd0, halt}, 32'd0);
  endtask

  task automatic run_illegal(input logic [31:0] bad);
    instr = bad;
    #1;
    chk("illegal c1 halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    #1;
    chk("illegal c2 halt", {31'd0, halt}, 32'd0);
    chk_idle("illegal c2");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt sticky", {31'd0, halt}, 32'd1);
      chk_idle("halted");
    end
    instr = 32'h00851021;
    chk("halt instret", instret, exp_cnt);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    exp_cnt = 0;
    chk("halt cleared", {31'd0, halt}, 32'd0);
    chk("instret cleared", instret, 32'd0);
    rst = 1;
  endtask

  initial begin
    vecs[0]  = '{32'h00851021, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(1,0,0,0,0,0,ALU_ADD,2'b00,MR_ALU,2'b00,0)};
    vecs[1]  = '{32'h8C820004, 5, 5'b10000, 5'b10000, 5'b00000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_MEM,2'b00,0)};
    vecs[2]  = '{32'hAC820004, 4, 5'b01000, 5'b00000, 5'b01000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_ALU,2'b00,0)};
    vecs[3]  = '{32'h0C000010, 3, 5'b00100, 5'b00100, 5'b00000, 6'b000010, st(0,1,0,0,0,0,ALU_ADD,2'b00,MR_PC4,2'b00,0)};
    vecs[4]  = '{32'h10850003, 3, 5'b00100, 5'b00000, 5'b00000, 6'b000100, st(0,0,0,0,0,1,ALU_SUB,2'b00,MR_ALU,2'b00,0)};
    vecs[5]  = '{32'h14850003, 3, 5'b00100, 5'b00000, 5'b00000, 6'b001000, st(0,0,0,0,0,1,ALU_SUB,2'b00,MR_ALU,2'b00,0)};
    vecs[6]  = '{32'h08000010, 3, 5'b00100, 5'b00000, 5'b00000, 6'b000010, st(0,0,0,0,0,0,ALU_ADD,2'b00,MR_ALU,2'b00,0)};
    vecs[7]  = '{32'h03E00008, 3, 5'b00100, 5'b00000, 5'b00000, 6'b000001, st(1,0,0,0,0,0,ALU_ADD,2'b00,MR_ALU,2'b00,0)};
    vecs[8]  = '{32'h0080F809, 3, 5'b00100, 5'b00100, 5'b00000, 6'b000001, st(1,0,0,0,0,0,ALU_ADD,2'b00,MR_PC4,2'b00,0)};
    vecs[9]  = '{32'h3482FFFF, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(0,0,0,1,0,0,ALU_OR,2'b00,MR_ALU,2'b00,0)};
    vecs[10] = '{32'h3C021234, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(0,0,0,1,0,0,ALU_LUI,2'b00,MR_LUI,2'b00,0)};
    vecs[11] = '{32'h0085102B, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(1,0,0,0,0,0,ALU_SUB,2'b11,MR_ALU,2'b00,0)};
    vecs[12] = '{32'h00A41004, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(1,0,1,0,1,0,ALU_SLL,2'b00,MR_ALU,2'b00,0)};
    vecs[13] = '{32'h00021082, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(1,0,1,0,0,0,ALU_SRL,2'b00,MR_ALU,2'b00,0)};
    vecs[14] = '{32'h80820004, 5, 5'b10000, 5'b10000, 5'b00000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_MEM,2'b11,0)};
    vecs[15] = '{32'h90820004, 5, 5'b10000, 5'b10000, 5'b00000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_MEM,2'b01,0)};
    vecs[16] = '{32'hA0820004, 4, 5'b01000, 5'b00000, 5'b01000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_ALU,2'b00,1)};
    vecs[17] = '{32'h24820005, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(0,0,0,1,0,1,ALU_ADD,2'b00,MR_ALU,2'b00,0)};
    vecs[18] = '{32'h0085102A, 4, 5'b01000, 5'b01000, 5'b00000, 6'b000000, st(1,0,0,0,0,0,ALU_SUB,2'b01,MR_ALU,2'b00,0)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset instret", instret, 32'd0);
    chk("reset halt", {31'd0, halt}, 32'd0);
    chk("reset Branch/Jump", {26'd0, Branch, Jump, Jreg}, 32'd0);
    rst = 1;
    foreach (vecs[i]) run_vec(i, vecs[i]);
    run_illegal(32'hFC000000);
    run_illegal(32'h0000003F);
    instr = 32'h00851021;
    #1;
    for (int c = 1; c < 4; c++) @(negedge clk);
    #1;
    chk("pre-reset WB strobes", {30'd0, PCWr, RegWr}, 32'd3);
    rst = 0;
    #1;
    chk_idle("reset mid-WB");
    @(posedge clk);
    @(negedge clk);
    chk("mid reset instret", instret, 32'd0);
    rst = 1;
    exp_cnt = 0;
    run_vec(100, vecs[0]);
    run_vec(101, vecs[3]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
